// File: rtl/io_clock_enables.sv
// rtl/io_clock_enables.sv - CPU, colour-clock and E-clock enable generator
// All outputs are registered from next-state decode so consumers see glitch-free enables on CLK.
module io_clock_enables #(
  parameter int CPU_DIV = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SYNC,
  output logic        CPU_EN,
  output logic        CCK,
  output logic        CCK_EN,
  output logic        ECLK,
  output logic        E_RISE_EN,
  output logic        E_FALL_EN,
  output logic [15:0] CCK_COUNT
);

  localparam int PW = $clog2(2 * CPU_DIV);
  localparam logic [PW-1:0] PH_CPU  = PW'(CPU_DIV - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(CPU_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CPU_DIV - 1);
  localparam logic [3:0]    E_RISE  = 4'd6;
  localparam logic [3:0]    E_LAST  = 4'd9;

  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    ecnt_q, ecnt_d;
  logic [15:0]   cck_count_q, cck_count_d;
  logic          cpu_en_q, cpu_en_d;
  logic          cck_q, cck_d;
  logic          cck_en_q, cck_en_d;
  logic          eclk_q, eclk_d;
  logic          e_rise_en_q, e_rise_en_d;
  logic          e_fall_en_q, e_fall_en_d;

  always_comb begin
    phase_d     = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    ecnt_d      = ecnt_q;
    cck_count_d = cck_count_q;
    if (cpu_en_q) begin
      ecnt_d = (ecnt_q == E_LAST) ? 4'd0 : ecnt_q + 4'd1;
    end
    if (cck_en_q) begin
      cck_count_d = cck_count_q + 16'd1;
    end
    // SYNC restarts the phase but must not eat or fake a colour-clock count
    if (SYNC) begin
      phase_d     = '0;
      ecnt_d      = 4'd0;
      cck_count_d = cck_count_q;
    end

    cpu_en_d    = !SYNC && ((phase_d == PH_CPU) || (phase_d == PH_LAST));
    cck_en_d    = !SYNC && (phase_d == PH_LAST);
    cck_d       = (phase_d < PH_HALF);
    eclk_d      = (ecnt_d >= E_RISE);
    e_rise_en_d = !SYNC && (ecnt_q == 4'd5) && (ecnt_d == E_RISE);
    e_fall_en_d = !SYNC && (ecnt_q == E_LAST) && (ecnt_d == 4'd0);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q     <= '0;
      ecnt_q      <= 4'd0;
      cck_count_q <= 16'd0;
      cpu_en_q    <= 1'b0;
      cck_q       <= 1'b1;
      cck_en_q    <= 1'b0;
      eclk_q      <= 1'b0;
      e_rise_en_q <= 1'b0;
      e_fall_en_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      ecnt_q      <= ecnt_d;
      cck_count_q <= cck_count_d;
      cpu_en_q    <= cpu_en_d;
      cck_q       <= cck_d;
      cck_en_q    <= cck_en_d;
      eclk_q      <= eclk_d;
      e_rise_en_q <= e_rise_en_d;
      e_fall_en_q <= e_fall_en_d;
    end
  end

  assign CPU_EN    = cpu_en_q;
  assign CCK       = cck_q;
  assign CCK_EN    = cck_en_q;
  assign ECLK      = eclk_q;
  assign E_RISE_EN = e_rise_en_q;
  assign E_FALL_EN = e_fall_en_q;
  assign CCK_COUNT = cck_count_q;

endmodule

// File: tb/tb_io_clock_enables.sv
// tb/tb_io_clock_enables.sv - directed checks of io_clock_enables for CPU_DIV 2, 4 and 8
module tb_io_clock_enables;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync   [3];
  logic        cpu_en [3];
  logic        cck    [3];
  logic        cck_en [3];
  logic        eclk   [3];
  logic        erise  [3];
  logic        efall  [3];
  logic [15:0] cnt    [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_clock_enables #(.CPU_DIV(2)) dut2 (
    .CLK(clk), .RESET_N(rst_n), .SYNC(sync[0]), .CPU_EN(cpu_en[0]), .CCK(cck[0]),
    .CCK_EN(cck_en[0]), .ECLK(eclk[0]), .E_RISE_EN(erise[0]), .E_FALL_EN(efall[0]),
    .CCK_COUNT(cnt[0]));
  io_clock_enables #(.CPU_DIV(4)) dut4 (
    .CLK(clk), .RESET_N(rst_n), .SYNC(sync[1]), .CPU_EN(cpu_en[1]), .CCK(cck[1]),
    .CCK_EN(cck_en[1]), .ECLK(eclk[1]), .E_RISE_EN(erise[1]), .E_FALL_EN(efall[1]),
    .CCK_COUNT(cnt[1]));
  io_clock_enables #(.CPU_DIV(8)) dut8 (
    .CLK(clk), .RESET_N(rst_n), .SYNC(sync[2]), .CPU_EN(cpu_en[2]), .CCK(cck[2]),
    .CCK_EN(cck_en[2]), .ECLK(eclk[2]), .E_RISE_EN(erise[2]), .E_FALL_EN(efall[2]),
    .CCK_COUNT(cnt[2]));

  // flags = {CPU_EN, CCK_EN, CCK, ECLK, E_RISE_EN, E_FALL_EN}
  typedef struct {
    int          cycle;
    logic [5:0]  flags;
    logic [15:0] count;
  } vec_t;

  localparam logic [5:0] RST_FLAGS = 6'b001000;

  vec_t tbl [16];

  function automatic logic [5:0] flags_of(input int k);
    return {cpu_en[k], cck_en[k], cck[k], eclk[k], erise[k], efall[k]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Expected outputs n cycles after a reset/SYNC restart, counter starting at base
  task automatic check_model(input int k, input int n, input logic [15:0] base, input string tag);
    int d;
    int m;
    int e;
    logic [5:0]  ef;
    logic [15:0] ec;
    d  = 2 << k;
    m  = n % (2 * d);
    e  = n % (10 * d);
    ef = {(m % d) == d - 1, m == 2 * d - 1, m < d, e >= 6 * d, e == 6 * d, (n > 0) && (e == 0)};
    ec = base + 16'(n / (2 * d));
    chk($sformatf("%s div%0d n%0d flags", tag, d, n), 32'(flags_of(k)), 32'(ef));
    chk($sformatf("%s div%0d n%0d count", tag, d, n), 32'(cnt[k]), 32'(ec));
  endtask

  initial begin
    int ti;
    int hi [3];

    tbl[0]  = '{0,   6'b001000, 16'd0};
    tbl[1]  = '{3,   6'b101000, 16'd0};
    tbl[2]  = '{4,   6'b000000, 16'd0};
    tbl[3]  = '{7,   6'b110000, 16'd0};
    tbl[4]  = '{8,   6'b001000, 16'd1};
    tbl[5]  = '{16,  6'b001000, 16'd2};
    tbl[6]  = '{23,  6'b110000, 16'd2};
    tbl[7]  = '{24,  6'b001110, 16'd3};
    tbl[8]  = '{25,  6'b001100, 16'd3};
    tbl[9]  = '{39,  6'b110100, 16'd4};
    tbl[10] = '{40,  6'b001001, 16'd5};
    tbl[11] = '{41,  6'b001000, 16'd5};
    tbl[12] = '{63,  6'b110000, 16'd7};
    tbl[13] = '{64,  6'b001110, 16'd8};
    tbl[14] = '{80,  6'b001001, 16'd10};
    tbl[15] = '{120, 6'b001001, 16'd15};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sync[k] = 1'b0;
      hi[k]   = 0;
    end

    // Reset values held while RESET_N is low
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("reset div%0d flags", 2 << k), 32'(flags_of(k)), 32'(RST_FLAGS));
        chk($sformatf("reset div%0d count", 2 << k), 32'(cnt[k]), 32'd0);
      end
    end

    // Free run: model for all three dividers plus hand-computed table for CPU_DIV=4
    rst_n = 1'b1;
    ti = 0;
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 3; k++) begin
        check_model(k, n, 16'd0, "run");
        if (n < 10 * (2 << k) && eclk[k]) hi[k]++;
      end
      if (ti < 16 && tbl[ti].cycle == n) begin
        chk($sformatf("tbl n%0d flags", n), 32'(flags_of(1)), 32'(tbl[ti].flags));
        chk($sformatf("tbl n%0d count", n), 32'(cnt[1]), 32'(tbl[ti].count));
        ti++;
      end
      step();
    end
    chk("tbl entries applied", 32'(ti), 32'd16);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("eclk high per period div%0d", 2 << k), 32'(hi[k]), 32'(4 * (2 << k)));
    end

    // SYNC mid-period at n=30
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) step();
    check_model(1, 30, 16'd0, "presync");
    sync[1] = 1'b1;
    step();
    sync[1] = 1'b0;
    chk("sync count held", 32'(cnt[1]), 32'd3);
    for (int n = 0; n < 31; n++) begin
      check_model(1, n, 16'd3, "sync");
      step();
    end
    check_model(1, 31, 16'd3, "sync");

    // SYNC on the edge leaving phase 7: the pending count increment is dropped
    sync[1] = 1'b1;
    step();
    sync[1] = 1'b0;
    chk("sync on cck_en count", 32'(cnt[1]), 32'd6);
    for (int n = 0; n < 41; n++) begin
      check_model(1, n, 16'd6, "sync7");
      step();
    end

    // Held SYNC freezes the block; counter forced near wrap meanwhile
    sync[1] = 1'b1;
    step();
    chk("hold sync flags 0", 32'(flags_of(1)), 32'(RST_FLAGS));
    force dut4.cck_count_q = 16'hFFFE;
    #1;
    release dut4.cck_count_q;
    for (int c = 1; c < 3; c++) begin
      step();
      chk($sformatf("hold sync flags %0d", c), 32'(flags_of(1)), 32'(RST_FLAGS));
      chk($sformatf("hold sync count %0d", c), 32'(cnt[1]), 32'hFFFE);
    end
    sync[1] = 1'b0;
    for (int n = 0; n < 18; n++) begin
      check_model(1, n, 16'hFFFE, "wrap");
      step();
    end
    chk("wrap final count", 32'(cnt[1]), 32'h0000);

    // Asynchronous reset between edges at n=27
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 27; n++) step();
    for (int k = 0; k < 3; k++) check_model(k, 27, 16'd0, "prereset");
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async reset div%0d flags", 2 << k), 32'(flags_of(k)), 32'(RST_FLAGS));
      chk($sformatf("async reset div%0d count", 2 << k), 32'(cnt[k]), 32'd0);
    end
    step();
    chk("async reset held flags", 32'(flags_of(1)), 32'(RST_FLAGS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_clock_enables.md
# io_clock_enables

Clock-enable generator that sits directly downstream of the master clock source. From the single fast CLK it derives glitch-free one-cycle enable pulses and phase levels for the CPU clock, the colour clock (CCK) and the 6800-style E clock. It also maintains a free-running CCK counter. Every other synchronous block in the design runs on CLK and qualifies its logic with these enables; none uses them as clocks.

## Interface
- CPU_DIV, 4, CLK cycles per CPU clock; even, ≥2. The CCK period is 2*CPU_DIV.
- CLK  input  1  master clock; all state changes on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- SYNC  input  1  synchronous phase restart, sampled on the rising CLK edge.
- CPU_EN  output  1  one-CLK pulse per CPU clock period.
- CCK  output  1  colour-clock level: high for the first half of each CCK period.
- CCK_EN  output  1  one-CLK pulse at the end of each CCK period.
- ECLK  output  1  E-clock level: low for 6 CPU clocks, then high for 4.
- E_RISE_EN  output  1  one-CLK pulse in the first cycle ECLK is high.
- E_FALL_EN  output  1  one-CLK pulse in the first cycle ECLK is low after being high.
- CCK_COUNT  output  16  free-running count of completed CCK periods.

## Operation
- **State**
  - phase: 0..2*CPU_DIV-1, advances by 1 every CLK and wraps to 0.
  - ecnt: 0..9, advances on each edge where CPU_EN is high, and wraps 9→0.
  - CCK_COUNT: 16-bit, increments on each edge where CCK_EN is high.
- **Decode** (all outputs are flops, loaded from next-state, so no combinational glitches):
  - CPU_EN = (phase==CPU_DIV-1) or (phase==2*CPU_DIV-1).
  - CCK_EN = (phase==2*CPU_DIV-1).
  - CCK = (phase < CPU_DIV).
  - ECLK = (ecnt ≥ 6).
  - E_RISE_EN is high in the single cycle after ecnt changes 5→6.
  - E_FALL_EN is high in the single cycle after ecnt changes 9→0.
- **Reset values** (asynchronous, while RESET_N=0):
  - phase=0, ecnt=0, CCK_COUNT=0.
  - CPU_EN=0, CCK_EN=0, CCK=1, ECLK=0, E_RISE_EN=0, E_FALL_EN=0.
- **SYNC**
  - At an edge with SYNC=1, phase and ecnt load 0 and all outputs take their reset values.
  - CCK_COUNT holds.
  - SYNC has priority over normal advance.
  - Any pulse that the next-state decode would have produced on that edge is suppressed. This includes a CCK_COUNT increment that coincides with SYNC.
  - Holding SYNC high for multiple cycles keeps the block frozen at phase 0.
- **Wrap-around**: CCK_COUNT wraps 0xFFFF→0x0000 with no flag.
- **Mid-operation reset**: a RESET_N assertion mid-period aborts immediately; no partial pulse is stretched.

## Timing
The values below are for CPU_DIV=4. Cycle n is the interval after the n-th rising edge following RESET_N release, where release is synchronised externally to CLK.
- phase equals n mod 8.
- CPU_EN is high in cycles 3, 7, 11, …; CCK_EN is high in cycles 7, 15, 23, ….
- CCK is high in cycles 0-3 and low in cycles 4-7, repeating every 8.
- CCK_COUNT = 1 from cycle 8 and 2 from cycle 16.
- ECLK is low in cycles 0-23, high in cycles 24-39, and low again from cycle 40.
  - The E period is 40 CLKs: 24 low, 16 high.
- E_RISE_EN is high only in cycles 24, 64, …; E_FALL_EN is high only in cycles 40, 80, ….
- No E_FALL_EN is produced after reset or after SYNC.
- Latency: an output is valid in the same cycle its decode condition holds on the registered state, with no extra pipeline stage.
- E_RISE_EN coincides with ECLK's first high cycle, never with a CPU_EN.
- Each E pulse is exactly 1 CLK wide, whatever the value of CPU_DIV.

## Test plan
- **Reset and free-run** (CPU_DIV=4): release RESET_N and run 100 cycles.
  - CPU_EN is high exactly at n ≡ 3 mod 4.
  - CCK_EN is high at n ≡ 7 mod 8.
  - CCK is high for n mod 8 < 4.
  - All reset values hold while RESET_N=0.
- **E clock**: run 200 cycles.
  - ECLK rises at 24, 64, 104 and falls at 40, 80, 120.
  - E_RISE_EN and E_FALL_EN are single-cycle pulses at exactly those cycles.
  - Per 40-cycle period: 16 high, 24 low.
- **SYNC mid-period**: assert SYNC for 1 cycle at n=30 (ecnt=7, phase=6).
  - At cycle 31, phase=0, CCK=1 and ECLK=0, with no E_FALL_EN.
  - The next CPU_EN is at cycle 34.
  - ECLK next rises 24 cycles after SYNC.
  - CCK_COUNT is unchanged (3).
- **SYNC coincident with CCK_EN edge**: assert SYNC at the edge leaving phase 7.
  - CCK_COUNT does not increment.
  - No CPU_EN or CCK_EN is lost or duplicated afterwards.
- **CCK_COUNT wrap**: force CCK_COUNT to 0xFFFE, then run 16 cycles.
  - Observed sequence: 0xFFFE → 0xFFFF → 0x0000.
- **Asynchronous reset mid-operation and parameter sweep**:
  - Drop RESET_N between edges at n=27: all outputs go to reset values without waiting for a CLK edge.
  - Repeat the free-run check with CPU_DIV=2 and CPU_DIV=8: E period is 20 and 80 CLKs respectively, with a 6:4 ratio.
